// File: rtl/pulse_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_pattern_gen
//  Description : Emits a three-pulse energy envelope on command. Each pulse
//                has a programmable width (plus a fixed WIDTH_OFFSET), and is
//                followed by a programmable low gap. The result is the
//                stimulus that the three-pulse energy-pattern matcher accepts.
//                Optional feature macro: PULSE_GEN_LOOP_EN (seamless repeat
//                of the pattern while loop_i is high).
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_pattern_gen #(
  parameter int WIDTH_OFFSET = 0,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          loop_i,
  input  logic [CW-1:0] width_1_i,
  input  logic [CW-1:0] width_2_i,
  input  logic [CW-1:0] width_3_i,
  input  logic [CW-1:0] gap_len_i,
  output logic          pulse_out_o,
  output logic          busy_o,
  output logic [1:0]    pulse_idx_o,
  output logic          sync_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Offset extended by one bit so that width + offset can be tested for overflow.
  localparam logic [CW:0]   C_OFFSET = (CW+1)'(WIDTH_OFFSET);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_ZERO   = '0;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] w2_q;
  logic [CW-1:0] w3_q;
  logic [CW-1:0] gap_q;
  logic          pulse_q;
  logic          busy_q;
  logic [1:0]    idx_q;
  logic          sync_q;
  logic          done_q;
  logic          w_loop_restart;

  // Counter load value for a pulse: saturating (width + offset), at least 1, minus 1.
  function automatic logic [CW-1:0] pulse_load(input logic [CW-1:0] w);
    logic [CW:0]   sum;
    logic [CW-1:0] eff;
    sum = {1'b0, w} + C_OFFSET;
    if (sum[CW]) begin
      eff = '1;
    end else if (sum[CW-1:0] == C_ZERO) begin
      eff = C_ONE;
    end else begin
      eff = sum[CW-1:0];
    end
    return eff - C_ONE;
  endfunction

  // Counter load value for a gap: a zero gap still lasts one cycle.
  function automatic logic [CW-1:0] gap_load(input logic [CW-1:0] g);
    return (g == C_ZERO) ? C_ZERO : (g - C_ONE);
  endfunction

`ifdef PULSE_GEN_LOOP_EN
  assign w_loop_restart = loop_i;
`else
  logic w_loop_unused;
  assign w_loop_unused  = loop_i;
  assign w_loop_restart = 1'b0;
`endif

  // Pattern sequencer: state, length latches, down-counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 2'd0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      done_q <= 1'b0;
      if (abort_i) begin
        // Abort wins over everything, including a simultaneous start.
        state_q <= S_IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        idx_q   <= 2'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              w2_q    <= width_2_i;
              w3_q    <= width_3_i;
              gap_q   <= gap_len_i;
              cnt_q   <= pulse_load(width_1_i);
              state_q <= S_PULSE;
              pulse_q <= 1'b1;
              sync_q  <= 1'b1;
              busy_q  <= 1'b1;
              idx_q   <= 2'd1;
            end
          end
          S_PULSE: begin
            if (cnt_q == C_ZERO) begin
              cnt_q   <= gap_load(gap_q);
              state_q <= S_GAP;
              pulse_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - C_ONE;
            end
          end
          S_GAP: begin
            if (cnt_q != C_ZERO) begin
              cnt_q <= cnt_q - C_ONE;
            end else if (idx_q != 2'd3) begin
              cnt_q   <= pulse_load((idx_q == 2'd1) ? w2_q : w3_q);
              idx_q   <= idx_q + 2'd1;
              state_q <= S_PULSE;
              pulse_q <= 1'b1;
              sync_q  <= 1'b1;
            end else if (w_loop_restart) begin
              // Seamless repeat: completion and the next pattern's first pulse share a cycle.
              w2_q    <= width_2_i;
              w3_q    <= width_3_i;
              gap_q   <= gap_len_i;
              cnt_q   <= pulse_load(width_1_i);
              idx_q   <= 2'd1;
              state_q <= S_PULSE;
              pulse_q <= 1'b1;
              sync_q  <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              idx_q   <= 2'd0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign pulse_out_o = pulse_q;
  assign busy_o      = busy_q;
  assign pulse_idx_o = idx_q;
  assign sync_o      = sync_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_pattern_gen
//  Description : Directed self-checking bench for pulse_pattern_gen. Three
//                instances share stimulus: offset 0 (CW 16), offset 64
//                (CW 16) and offset 64 with CW 8 for cheap saturation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_pattern_gen;

`ifdef PULSE_GEN_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] width_1 = '0;
  logic [15:0] width_2 = '0;
  logic [15:0] width_3 = '0;
  logic [15:0] gap_len = '0;

  logic       p0, b0, s0, d0;
  logic [1:0] i0;
  logic       p1, b1, s1, d1;
  logic [1:0] i1;
  logic       p2, b2, s2, d2;
  logic [1:0] i2;

  logic       o_p, o_b, o_s, o_d;
  logic [1:0] o_i;
  int         cur_sel = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_pattern_gen #(.WIDTH_OFFSET(0), .CW(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .loop_i(loop),
    .width_1_i(width_1), .width_2_i(width_2), .width_3_i(width_3), .gap_len_i(gap_len),
    .pulse_out_o(p0), .busy_o(b0), .pulse_idx_o(i0), .sync_o(s0), .done_o(d0)
  );

  pulse_pattern_gen #(.WIDTH_OFFSET(64), .CW(16)) dut_off (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .loop_i(loop),
    .width_1_i(width_1), .width_2_i(width_2), .width_3_i(width_3), .gap_len_i(gap_len),
    .pulse_out_o(p1), .busy_o(b1), .pulse_idx_o(i1), .sync_o(s1), .done_o(d1)
  );

  pulse_pattern_gen #(.WIDTH_OFFSET(64), .CW(8)) dut_sat (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .loop_i(loop),
    .width_1_i(width_1[7:0]), .width_2_i(width_2[7:0]), .width_3_i(width_3[7:0]),
    .gap_len_i(gap_len[7:0]),
    .pulse_out_o(p2), .busy_o(b2), .pulse_idx_o(i2), .sync_o(s2), .done_o(d2)
  );

  // Observation mux: the instance currently under test.
  always_comb begin
    o_p = p0; o_b = b0; o_s = s0; o_d = d0; o_i = i0;
    if (cur_sel == 1) begin
      o_p = p1; o_b = b1; o_s = s1; o_d = d1; o_i = i1;
    end else if (cur_sel == 2) begin
      o_p = p2; o_b = b2; o_s = s2; o_d = d2; o_i = i2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_len(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] g);
    width_1 = a; width_2 = b; width_3 = c; gap_len = g;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  // Issue start at the current negedge and compare every cycle of the pattern,
  // up to and including the done cycle, against a waveform built from the
  // effective lengths e1/e2/e3/eg. Length inputs are scrambled mid-pattern.
  task automatic run_pat(input string tag, input int sel, input int e1, input int e2,
                         input int e3, input int eg, input bit hold, input bit lp);
    int total, u, ek, first;
    int bad_p, bad_s, bad_b, bad_i, bad_d;
    logic ep, es, eb, ed;
    logic [1:0] ei;
    total = e1 + e2 + e3 + 3 * eg;
    cur_sel = sel;
    first = -1;
    bad_p = 0; bad_s = 0; bad_b = 0; bad_i = 0; bad_d = 0;
    start = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= total + 1; t++) begin
      ep = 1'b0; es = 1'b0; eb = 1'b0; ed = 1'b0; ei = 2'd0;
      if (t <= total) begin
        eb = 1'b1;
        u  = t;
        for (int k = 1; k <= 3; k++) begin
          ek = (k == 1) ? e1 : ((k == 2) ? e2 : e3);
          if (u >= 1 && u <= ek) begin
            ep = 1'b1; es = (u == 1); ei = 2'(k);
          end else if (u > ek && u <= ek + eg) begin
            ei = 2'(k);
          end
          u = u - ek - eg;
        end
      end else begin
        ed = 1'b1;
        if (lp) begin
          ep = 1'b1; es = 1'b1; eb = 1'b1; ei = 2'd1;
        end
      end
      if (o_p !== ep) bad_p++;
      if (o_s !== es) bad_s++;
      if (o_b !== eb) bad_b++;
      if (o_i !== ei) bad_i++;
      if (o_d !== ed) bad_d++;
      if (first < 0 && (o_p !== ep || o_s !== es || o_b !== eb || o_i !== ei || o_d !== ed))
        first = t;
      start = hold && (t < total);
      if (t == 10) set_len(16'd3, 16'd3, 16'd3, 16'd3);
      if (t <= total) @(negedge clk);
    end
    start = 1'b0;
    if (first >= 0) $display("note %s: first deviating cycle t=%0d", tag, first);
    chk({tag, " pulse_out bad cycles"}, bad_p, 0);
    chk({tag, " sync bad cycles"},      bad_s, 0);
    chk({tag, " busy bad cycles"},      bad_b, 0);
    chk({tag, " pulse_idx bad cycles"}, bad_i, 0);
    chk({tag, " done bad cycles"},      bad_d, 0);
  endtask

  int n_done, n_busy;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset pulse_out", p0, 1'b0);
    chk("reset busy", b0, 1'b0);
    chk("reset pulse_idx", i0, 2'd0);
    chk("reset sync", s0, 1'b0);
    chk("reset done", d0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset busy", b0, 1'b0);
    chk("idle after reset pulse_out", p1, 1'b0);

    // Nominal pattern, offset 0
    set_len(16'd500, 16'd750, 16'd1000, 16'd2000);
    run_pat("nominal", 0, 500, 750, 1000, 2000, 1'b0, 1'b0);

    // Same lengths with offset 64
    repeat (300) @(negedge clk);
    set_len(16'd500, 16'd750, 16'd1000, 16'd2000);
    run_pat("offset64", 1, 564, 814, 1064, 2000, 1'b0, 1'b0);
    do_abort();

    // Zero lengths; start held high while busy; then restart in the done cycle
    set_len(16'd0, 16'd0, 16'd0, 16'd0);
    run_pat("zero_hold", 0, 1, 1, 1, 1, 1'b1, 1'b0);
    run_pat("zero_restart", 0, 1, 1, 1, 1, 1'b0, 1'b0);
    do_abort();

    // Saturation: 0xF0 + 64 exceeds 8 bits -> 255; zero widths -> 64; zero gap -> 1
    set_len(16'h00F0, 16'd0, 16'd0, 16'd0);
    run_pat("saturate", 2, 255, 64, 64, 1, 1'b0, 1'b0);
    do_abort();

    // Abort during pulse 2, cycle 100
    cur_sel = 0;
    set_len(16'd500, 16'd750, 16'd1000, 16'd2000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2599) @(negedge clk);
    chk("pre-abort pulse_out", p0, 1'b1);
    chk("pre-abort pulse_idx", i0, 2'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort pulse_out", p0, 1'b0);
    chk("abort busy", b0, 1'b0);
    chk("abort pulse_idx", i0, 2'd0);
    chk("abort done", d0, 1'b0);
    n_done = 0;
    n_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (d0) n_done++;
      if (b0) n_busy++;
    end
    chk("abort no later done", n_done, 0);
    chk("abort stays idle", n_busy, 0);

    // Abort together with start in IDLE: start rejected
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort+start busy", b0, 1'b0);
    chk("abort+start pulse_out", p0, 1'b0);
    chk("abort+start sync", s0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort+start still idle", b0, 1'b0);

    // Loop request: repeats only when the feature is built in
    loop = 1'b1;
    set_len(16'd500, 16'd750, 16'd1000, 16'd100);
    run_pat("loop", 0, 500, 750, 1000, 100, 1'b0, LOOP_BUILD);
    @(negedge clk);
    chk("loop busy after done", b0, LOOP_BUILD);
    chk("loop pulse after done", p0, LOOP_BUILD);
    loop = 1'b0;
    do_abort();

    // Asynchronous reset mid-gap 1, then a full nominal pattern
    cur_sel = 0;
    set_len(16'd500, 16'd750, 16'd1000, 16'd2000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (599) @(negedge clk);
    chk("gap1 busy", b0, 1'b1);
    chk("gap1 pulse_idx", i0, 2'd1);
    rst = 1'b1;
    #1;
    chk("async reset busy", b0, 1'b0);
    chk("async reset pulse_idx", i0, 2'd0);
    chk("async reset pulse_out", p0, 1'b0);
    @(negedge clk);
    chk("reset held done", d0, 1'b0);
    rst = 1'b0;
    set_len(16'd500, 16'd750, 16'd1000, 16'd2000);
    run_pat("post_reset", 0, 500, 750, 1000, 2000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
